// File: rtl/burst_tone_pkg.sv
// Shared types and default timing constants for the burst tone generator.
package burst_tone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } tone_state_t;

  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_TONE_HZ   = 40_000;
  localparam int DEF_HALF_CLKS = DEF_CLK_HZ / (2 * DEF_TONE_HZ);

endpackage

// File: rtl/tone_half_timer.sv
// Loadable down-counter; tc is high whenever the count sits at zero.
// Holds at zero instead of wrapping, so an unloaded timer stays expired.
module tone_half_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/burst_tone_gen.sv
// Gated square-wave burst: optional start delay, then N tone cycles.
// state | meaning
// IDLE  | waiting for start_in
// DELAY | counting out D+1 clocks of start delay
// HIGH  | high half of a tone cycle
// LOW   | low half of a tone cycle; last one ends the burst
module burst_tone_gen
  import burst_tone_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TONE_HZ   = DEF_TONE_HZ,
  parameter int HALF_CLKS = CLK_HZ / (2 * TONE_HZ),
  parameter int CNT_W     = 16,
  parameter int BURST_W   = 8,
  parameter int DELAY_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [BURST_W-1:0] n_cycles_in,
  input  logic [DELAY_W-1:0] delay_in,
  output logic               sig_out,
  output logic               busy_out,
  output logic               done_out
);

  // A half period spans HALF_CLKS clocks: load HALF_CLKS-1, exit when tc.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CLKS - 1);

  tone_state_t        state_q, state_d;
  logic [BURST_W-1:0] cyc_q, cyc_d;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_tc;
  logic               finish;
  logic               sig_d, busy_d, done_d;

  tone_half_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      sig_out  <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      sig_out  <= sig_d;
      busy_out <= busy_d;
      done_out <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d  = DELAY;
          cyc_d    = n_cycles_in;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(delay_in);
        end
      end
      DELAY: begin
        if (tmr_tc) begin
          if (cyc_q != '0) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HALF_LOAD;
          end else begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      HIGH: begin
        if (tmr_tc) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end
      end
      LOW: begin
        if (tmr_tc) begin
          cyc_d = cyc_q - BURST_W'(1);
          if (cyc_q == BURST_W'(1)) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HALF_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are next-state decodes, registered alongside the state.
  always_comb begin
    sig_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = finish;
  end

endmodule

// File: tb/tb_burst_tone_gen.sv
// Self-checking bench for burst_tone_gen with HALF_CLKS=4; expected outputs
// come from a timeline model of each accepted burst (start edge, N, D).
module tb_burst_tone_gen;

  localparam int H       = 4;
  localparam int BURST_W = 8;
  localparam int DELAY_W = 16;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               start_in;
  logic [BURST_W-1:0] n_cycles_in;
  logic [DELAY_W-1:0] delay_in;
  logic               sig_out;
  logic               busy_out;
  logic               done_out;

  int checks = 0;
  int errors = 0;

  int edge_n = 0;
  bit b_act  = 1'b0;
  int b_k    = 0;
  int b_n    = 0;
  int b_d    = 0;

  always #10 clk_in = ~clk_in;

  burst_tone_gen #(
    .HALF_CLKS (H),
    .CNT_W     (16),
    .BURST_W   (BURST_W),
    .DELAY_W   (DELAY_W)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .n_cycles_in (n_cycles_in),
    .delay_in    (delay_in),
    .sig_out     (sig_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  function automatic int burst_len();
    return 1 + b_d + 2 * H * b_n;
  endfunction

  // True once the current burst has reached (or passed) its done edge.
  function automatic bit model_idle();
    return !b_act || (edge_n >= b_k + burst_len());
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic step();
    logic e_sig, e_busy, e_done;
    int   t;
    @(posedge clk_in);
    edge_n++;
    if (rst_in) begin
      b_act = 1'b0;
    end else if (start_in && (!b_act || edge_n > b_k + burst_len())) begin
      b_act = 1'b1;
      b_k   = edge_n;
      b_n   = int'(n_cycles_in);
      b_d   = int'(delay_in);
    end
    #1;
    e_sig  = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (b_act) begin
      t      = edge_n - b_k;
      e_busy = (t < burst_len());
      e_done = (t == burst_len());
      if (t >= 1 + b_d && t < burst_len())
        e_sig = (((t - 1 - b_d) / H) % 2) == 0;
    end
    chk("sig_out", sig_out, e_sig);
    chk("busy_out", busy_out, e_busy);
    chk("done_out", done_out, e_done);
  endtask

  // Start one burst, scramble the inputs while it runs, step past its end.
  task automatic run_burst(input int n, input int d);
    int guard;
    n_cycles_in = BURST_W'(n);
    delay_in    = DELAY_W'(d);
    start_in    = 1'b1;
    step();
    start_in    = 1'b0;
    n_cycles_in = BURST_W'($urandom);
    delay_in    = DELAY_W'($urandom);
    guard = 0;
    while (!model_idle() && guard < 70000) begin
      step();
      guard++;
    end
    step();
  endtask

  initial begin
    rst_in      = 1'b1;
    start_in    = 1'b0;
    n_cycles_in = '0;
    delay_in    = '0;
    repeat (3) step();
    rst_in = 1'b0;

    repeat (50) step();

    run_burst(3, 0);
    run_burst(2, 10);
    run_burst(0, 5);

    // Held start: back-to-back single-cycle bursts, restart only after done.
    n_cycles_in = 8'd1;
    delay_in    = 16'd0;
    start_in    = 1'b1;
    repeat (25) step();
    start_in = 1'b0;
    repeat (12) step();

    // Randomised bursts with stray starts and input churn mid-burst.
    for (int i = 0; i < 12; i++) begin
      n_cycles_in = BURST_W'($urandom_range(0, 5));
      delay_in    = DELAY_W'($urandom_range(0, 15));
      start_in    = 1'b1;
      step();
      for (int j = 0; j < 60; j++) begin
        start_in    = ($urandom_range(0, 9) == 0);
        n_cycles_in = BURST_W'($urandom_range(0, 5));
        delay_in    = DELAY_W'($urandom_range(0, 15));
        step();
      end
    end
    start_in = 1'b0;
    for (int g = 0; g < 200 && !model_idle(); g++) step();
    repeat (2) step();

    // Counter extremes.
    run_burst(255, 0);
    run_burst(1, 65535);

    // Asynchronous reset in the middle of a HIGH half period.
    n_cycles_in = 8'd5;
    delay_in    = 16'd2;
    start_in    = 1'b1;
    step();
    start_in = 1'b0;
    repeat (5) step();
    chk("sig_out_high_before_rst", sig_out, 1'b1);
    #3;
    rst_in = 1'b1;
    #1;
    b_act = 1'b0;
    chk("rst_async_sig", sig_out, 1'b0);
    chk("rst_async_busy", busy_out, 1'b0);
    chk("rst_async_done", done_out, 1'b0);
    repeat (3) step();
    #2;
    rst_in = 1'b0;
    repeat (4) step();
    run_burst(2, 3);
    run_burst(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
